// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: EX forwarding selects, load-use stall and redirect flushes.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_forward_ctrl #(
   parameter int REG_AW   = 5,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_reg_write,
   input  logic [REG_AW-1:0] id_wr_addr,
   input  logic              id_is_load,
   input  logic              ex_redirect,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              flush_ifid,
   output logic              flush_idex
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(ZERO_REG);

   logic              idex_vld_p0;
   logic              idex_rw_p0;
   logic              idex_ld_p0;
   logic              idex_urs_p0;
   logic              idex_urt_p0;
   logic [REG_AW-1:0] idex_wa_p0;
   logic [REG_AW-1:0] idex_rs_p0;
   logic [REG_AW-1:0] idex_rt_p0;
   logic              exmem_rw_p1;
   logic [REG_AW-1:0] exmem_wa_p1;
   logic              memwb_rw_p2;
   logic [REG_AW-1:0] memwb_wa_p2;

   logic luse;
   logic bubble;

   function automatic logic [1:0] fwd_sel(
      input logic              vld,
      input logic              uses,
      input logic [REG_AW-1:0] src,
      input logic              rw1,
      input logic [REG_AW-1:0] wa1,
      input logic              rw2,
      input logic [REG_AW-1:0] wa2
   );
      if (!vld || !uses || src == ZERO_A) return 2'd0;
      if (rw1 && wa1 == src)              return 2'd1;
      if (rw2 && wa2 == src)              return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
      if (en && cnt != 32'hFFFF_FFFF) return cnt + 32'd1;
      return cnt;
   endfunction

   assign luse = id_valid && idex_vld_p0 && idex_ld_p0 && idex_rw_p0 &&
                 (idex_wa_p0 != ZERO_A) &&
                 ((id_uses_rs && id_rs == idex_wa_p0) ||
                  (id_uses_rt && id_rt == idex_wa_p0));

   assign bubble = stall || ex_redirect || !id_valid;

   always_comb begin
      fwd_a      = fwd_sel(idex_vld_p0, idex_urs_p0, idex_rs_p0,
                           exmem_rw_p1, exmem_wa_p1, memwb_rw_p2, memwb_wa_p2);
      fwd_b      = fwd_sel(idex_vld_p0, idex_urt_p0, idex_rt_p0,
                           exmem_rw_p1, exmem_wa_p1, memwb_rw_p2, memwb_wa_p2);
      stall      = 1'b0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      if (!reset_n) begin
         fwd_a = 2'd0;
         fwd_b = 2'd0;
      end else if (ex_redirect) begin
         // A redirect wins over load-use: the would-be stalled instruction is on the wrong path.
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (luse) begin
         stall      = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end
   end

   // ID -> ID/EX (p0) -> EX/MEM (p1) -> MEM/WB (p2)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idex_vld_p0 <= 1'b0;
         idex_rw_p0  <= 1'b0;
         idex_ld_p0  <= 1'b0;
         idex_urs_p0 <= 1'b0;
         idex_urt_p0 <= 1'b0;
         idex_wa_p0  <= '0;
         idex_rs_p0  <= '0;
         idex_rt_p0  <= '0;
         exmem_rw_p1 <= 1'b0;
         exmem_wa_p1 <= '0;
         memwb_rw_p2 <= 1'b0;
         memwb_wa_p2 <= '0;
      end else begin
         idex_vld_p0 <= !bubble;
         idex_rw_p0  <= !bubble && id_reg_write;
         idex_ld_p0  <= id_is_load;
         idex_urs_p0 <= id_uses_rs;
         idex_urt_p0 <= id_uses_rt;
         idex_wa_p0  <= id_wr_addr;
         idex_rs_p0  <= id_rs;
         idex_rt_p0  <= id_rt;
         exmem_rw_p1 <= idex_vld_p0 && idex_rw_p0;
         exmem_wa_p1 <= idex_wa_p0;
         memwb_rw_p2 <= exmem_rw_p1;
         memwb_wa_p2 <= exmem_wa_p1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         stall_cnt <= sat_inc(stall_cnt, stall);
         flush_cnt <= sat_inc(flush_cnt, ex_redirect);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios plus randomized traffic against an
// instruction-level pipeline model. Define HAZARD_PERF_CNT_EN to also exercise the counters.
module tb_hazard_forward_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_wr_addr;
   logic       id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
   logic       ex_redirect;
   logic [1:0] fwd_a, fwd_b;
   logic       stall, pc_write, ifid_write, flush_ifid, flush_idex;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   hazard_forward_ctrl #(.REG_AW(5), .ZERO_REG(0)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
      .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .pc_write(pc_write),
      .ifid_write(ifid_write), .flush_ifid(flush_ifid), .flush_idex(flush_idex)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the instruction records currently sitting in EX, MEM and WB.
   typedef struct packed {
      logic       valid, rw, ld, urs, urt;
      logic [4:0] wa, rs, rt;
   } instr_t;

   instr_t m_ex, m_mem, m_wb, id_instr;
   logic [31:0] m_sc, m_fc;

   always_comb begin
      id_instr       = '0;
      id_instr.valid = id_valid;
      id_instr.rw    = id_reg_write;
      id_instr.ld    = id_is_load;
      id_instr.urs   = id_uses_rs;
      id_instr.urt   = id_uses_rt;
      id_instr.wa    = id_wr_addr;
      id_instr.rs    = id_rs;
      id_instr.rt    = id_rt;
   end

   function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic used);
      if (!m_ex.valid || !used || r == 5'd0) return 2'd0;
      if (m_mem.valid && m_mem.rw && m_mem.wa == r) return 2'd1;
      if (m_wb.valid && m_wb.rw && m_wb.wa == r) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic m_luse();
      if (!id_valid || !m_ex.valid || !m_ex.ld || !m_ex.rw || m_ex.wa == 5'd0) return 1'b0;
      return (id_uses_rs && id_rs == m_ex.wa) || (id_uses_rt && id_rt == m_ex.wa);
   endfunction

   // {fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex}
   function automatic logic [8:0] m_expect();
      logic [1:0] fa, fb;
      if (!reset_n) return 9'b00_00_01100;
      fa = m_fwd(m_ex.rs, m_ex.urs);
      fb = m_fwd(m_ex.rt, m_ex.urt);
      if (ex_redirect) return {fa, fb, 5'b01111};
      if (m_luse())    return {fa, fb, 5'b10000};
      return {fa, fb, 5'b01100};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ex  <= '0;
         m_mem <= '0;
         m_wb  <= '0;
         m_sc  <= '0;
         m_fc  <= '0;
      end else begin
         m_wb  <= m_mem;
         m_mem <= m_ex;
         m_ex  <= (ex_redirect || m_luse() || !id_valid) ? '0 : id_instr;
         if (m_luse() && !ex_redirect && m_sc != 32'hFFFF_FFFF) m_sc <= m_sc + 1;
         if (ex_redirect && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
      end
   end

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw,
                         input logic [4:0] wa, input logic ld);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_reg_write = rw; id_wr_addr = wa; id_is_load = ld;
   endtask

   task automatic add_i(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      set_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, 1'b0);
   endtask
   task automatic lw_i(input logic [4:0] rt, input logic [4:0] base);
      set_id(1'b1, base, rt, 1'b1, 1'b0, 1'b1, rt, 1'b1);
   endtask
   task automatic addi_i(input logic [4:0] rt, input logic [4:0] rs);
      set_id(1'b1, rs, rt, 1'b1, 1'b0, 1'b1, rt, 1'b0);
   endtask
   task automatic nop_i();  set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); endtask
   task automatic idle_i(); set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      ex_redirect = 1'b0;
      repeat (3) begin
         tick();
         idle_i();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ex_redirect = 1'b1;
      lw_i(5'd5, 5'd1);
      #3;
      n_total++;
      if ({fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex} !== 9'b00_00_01100)
         $display("FAIL reset_outputs got=%b want=%b",
                  {fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex}, 9'b00_00_01100);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ex_redirect = 1'b0;
      idle_i();
      reset_n = 1'b1;
      #1;
      n_total++;
      if ({fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex} !== 9'b00_00_01100)
         $display("FAIL reset_release got=%b want=%b",
                  {fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex}, 9'b00_00_01100);
      else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
      n_total++;
      if ({stall_cnt, flush_cnt} !== 64'd0)
         $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      drain();
      tick(); add_i(5'd3, 5'd1, 5'd2); #1;
      n_total++;
      if (stall !== 1'b0) $display("FAIL b2b_stall_first got=%b want=0", stall); else n_pass++;
      tick(); add_i(5'd4, 5'd3, 5'd5); #1;
      n_total++;
      if (stall !== 1'b0) $display("FAIL b2b_stall_second got=%b want=0", stall); else n_pass++;
      tick(); idle_i(); #1;
      n_total++;
      if ({fwd_a, fwd_b, stall} !== {2'd1, 2'd0, 1'b0})
         $display("FAIL b2b_fwd got fa=%0d fb=%0d st=%b want fa=1 fb=0 st=0", fwd_a, fwd_b, stall);
      else n_pass++;
   endtask

   task automatic test_mem_forward();
      drain();
      tick(); add_i(5'd3, 5'd1, 5'd2);
      tick(); nop_i();
      tick(); add_i(5'd6, 5'd7, 5'd3);
      tick(); idle_i(); #1;
      n_total++;
      if ({fwd_a, fwd_b} !== {2'd0, 2'd2})
         $display("FAIL memwb_fwd got fa=%0d fb=%0d want fa=0 fb=2", fwd_a, fwd_b);
      else n_pass++;
      tick(); add_i(5'd3, 5'd1, 5'd2);
      tick(); add_i(5'd3, 5'd4, 5'd5);
      tick(); add_i(5'd8, 5'd3, 5'd3);
      tick(); idle_i(); #1;
      n_total++;
      if ({fwd_a, fwd_b} !== {2'd1, 2'd1})
         $display("FAIL youngest_wins got fa=%0d fb=%0d want fa=1 fb=1", fwd_a, fwd_b);
      else n_pass++;
   endtask

   task automatic test_load_use();
      drain();
      tick(); lw_i(5'd5, 5'd1); #1;
      n_total++;
      if (stall !== 1'b0) $display("FAIL lu_no_early_stall got=%b want=0", stall); else n_pass++;
      tick(); add_i(5'd6, 5'd5, 5'd5); #1;
      n_total++;
      if ({stall, pc_write, ifid_write} !== 3'b100)
         $display("FAIL lu_stall got=%b want=100", {stall, pc_write, ifid_write});
      else n_pass++;
      tick(); add_i(5'd6, 5'd5, 5'd5); #1;
      n_total++;
      if ({stall, pc_write, ifid_write} !== 3'b011)
         $display("FAIL lu_one_cycle got=%b want=011", {stall, pc_write, ifid_write});
      else n_pass++;
      tick(); idle_i(); #1;
      n_total++;
      if ({fwd_a, fwd_b, stall} !== {2'd2, 2'd2, 1'b0})
         $display("FAIL lu_fwd got fa=%0d fb=%0d st=%b want fa=2 fb=2 st=0", fwd_a, fwd_b, stall);
      else n_pass++;
   endtask

   task automatic test_zero_reg_and_jal();
      drain();
      tick(); addi_i(5'd0, 5'd1);
      tick(); add_i(5'd2, 5'd0, 5'd0);
      tick(); idle_i(); #1;
      n_total++;
      if ({fwd_a, fwd_b} !== 4'd0)
         $display("FAIL zero_no_fwd got fa=%0d fb=%0d want fa=0 fb=0", fwd_a, fwd_b);
      else n_pass++;
      tick(); lw_i(5'd0, 5'd1);
      tick(); add_i(5'd2, 5'd0, 5'd0); #1;
      n_total++;
      if ({stall, pc_write} !== 2'b01)
         $display("FAIL zero_no_stall got=%b want=01", {stall, pc_write});
      else n_pass++;
      tick(); set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0);
      tick(); add_i(5'd9, 5'd31, 5'd0);
      tick(); idle_i(); #1;
      n_total++;
      if ({fwd_a, fwd_b} !== {2'd1, 2'd0})
         $display("FAIL jal_fwd got fa=%0d fb=%0d want fa=1 fb=0", fwd_a, fwd_b);
      else n_pass++;
   endtask

   task automatic test_redirect();
      drain();
      tick(); lw_i(5'd5, 5'd1);
      tick(); add_i(5'd6, 5'd5, 5'd5); ex_redirect = 1'b1; #1;
      n_total++;
      if ({fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex} !== 9'b00_00_01111)
         $display("FAIL redirect_over_stall got=%b want=%b",
                  {fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex}, 9'b00_00_01111);
      else n_pass++;
      tick(); ex_redirect = 1'b0; add_i(5'd7, 5'd6, 5'd6); #1;
      n_total++;
      if ({fwd_a, fwd_b, stall, flush_ifid, flush_idex} !== 7'd0)
         $display("FAIL redirect_bubble got=%b want=0000000",
                  {fwd_a, fwd_b, stall, flush_ifid, flush_idex});
      else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      drain();
      tick(); lw_i(5'd5, 5'd1);
      tick(); add_i(5'd6, 5'd5, 5'd5); #1;
      n_total++;
      if (stall !== 1'b1) $display("FAIL mid_pre_stall got=%b want=1", stall); else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({stall, pc_write, ifid_write} !== 3'b011)
         $display("FAIL mid_reset_async got=%b want=011", {stall, pc_write, ifid_write});
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      idle_i();
      reset_n = 1'b1;
      repeat (3) begin
         tick(); #1;
         n_total++;
         if ({fwd_a, fwd_b, stall, pc_write} !== 6'b0000_01)
            $display("FAIL mid_after_release got=%b want=000001", {fwd_a, fwd_b, stall, pc_write});
         else n_pass++;
      end
`ifdef HAZARD_PERF_CNT_EN
      n_total++;
      if ({stall_cnt, flush_cnt} !== 64'd0)
         $display("FAIL mid_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      logic [8:0] got, want;
      logic [4:0] wa;
      for (int i = 0; i < 400; i++) begin
         tick();
         wa = ($urandom_range(0, 4) == 4) ? 5'd31 : 5'($urandom_range(0, 3));
         set_id($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 80, wa, $urandom_range(0, 99) < 35);
         ex_redirect = ($urandom_range(0, 99) < 8);
         #1;
         got  = {fwd_a, fwd_b, stall, pc_write, ifid_write, flush_ifid, flush_idex};
         want = m_expect();
         n_total++;
         if (got !== want) $display("FAIL rand_cycle%0d got=%b want=%b", i, got, want);
         else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
         n_total++;
         if (stall_cnt !== m_sc || flush_cnt !== m_fc)
            $display("FAIL rand_counters%0d got=%0d/%0d want=%0d/%0d", i, stall_cnt, flush_cnt, m_sc, m_fc);
         else n_pass++;
`endif
      end
      ex_redirect = 1'b0;
   endtask

   initial begin
      ex_redirect = 1'b0;
      reset_n = 1'b0;
      idle_i();
      test_reset();
      test_back_to_back();
      test_mem_forward();
      test_load_use();
      test_zero_reg_and_jal();
      test_redirect();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
